// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports; data wins, with a streak limit to avoid fetch starvation.
// Optional watchdog abort is enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DM_STREAK   = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_rd_i,
    input  logic              dm_wr_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              served_dm_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic dm_req;
    logic busy;
    logic grant_dm;
    logic grant_if;
    logic mem_done;
    logic mem_abort;
    logic wdog_expired;

    assign dm_req = dm_rd_i | dm_wr_i;
    assign busy   = (state_q == DM_BUSY) || (state_q == IF_BUSY);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // The streak only grows while a fetch is actually waiting behind data grants.
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        mem_done  = 1'b0;
        mem_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req && !(if_req_i && (streak_q == 4'(DM_STREAK)))) begin
                    grant_dm = 1'b1;
                    state_d  = DM_BUSY;
                    streak_d = if_req_i ? streak_q + 4'd1 : 4'd0;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                    state_d  = IF_BUSY;
                    streak_d = 4'd0;
                end else begin
                    streak_d = 4'd0;
                end
            end
            DM_BUSY, IF_BUSY: begin
                if (mem_ack_i) begin
                    mem_done = 1'b1;
                    state_d  = RESP;
                end else if (wdog_expired) begin
                    mem_abort = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = busy;
        if_ack_o  = (state_q == RESP) && !served_dm_q;
        dm_ack_o  = (state_q == RESP) && served_dm_q;
        stall_o   = !rst_i && ((if_req_i && !if_ack_o) || (dm_req && !dm_ack_o));
    end

    // An aborted access returns zero to whichever read register was waiting on it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            served_dm_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant_dm) begin
                served_dm_q <= 1'b1;
                mem_addr_q  <= dm_addr_i;
                mem_we_q    <= dm_wr_i;
                mem_wdata_q <= dm_wdata_i;
            end else if (grant_if) begin
                served_dm_q <= 1'b0;
                mem_addr_q  <= if_addr_i;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
            end
            if (mem_done || mem_abort) begin
                if (served_dm_q) begin
                    if (!mem_we_q) dm_rdata_q <= mem_done ? mem_rdata_i : '0;
                end else begin
                    if_data_q <= mem_done ? mem_rdata_i : '0;
                end
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              err_q;

    // The expiry is seen in the last allowed busy cycle, so an ack there still wins.
    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (grant_dm || grant_if) wdog_q <= '0;
            else if (busy)            wdog_q <= wdog_q + 1'b1;
            if (mem_abort)            err_q  <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign wdog_expired       = 1'b0;
    assign err_o              = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector tables plus hand-written multi-cycle sequences.
// Define MEM_PORT_ARBITER_TIMEOUT_EN for both files to include the watchdog sequence.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        dm_rd_i = 1'b0;
    logic        dm_wr_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        err_o;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .DM_STREAK(2), .TIMEOUT_CYC(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_rd_i(dm_rd_i), .dm_wr_i(dm_wr_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_rd;
        logic        dm_wr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_ack;
        logic        e_dm_ack;
        logic        e_stall;
        logic [31:0] e_if_data;
        logic [31:0] e_dm_rdata;
    } vec_t;

    vec_t        vecs[$];
    logic [0:0]  exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic ma, input logic [31:0] md,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                       input logic eia, input logic eda, input logic es, input logic [31:0] eid,
                       input logic [31:0] edd);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_rd = dr; v.dm_wr = dw; v.dm_addr = da; v.dm_wdata = dd;
        v.mem_ack = ma; v.mem_rdata = md; v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_wdata = ed;
        v.e_if_ack = eia; v.e_dm_ack = eda; v.e_stall = es; v.e_if_data = eid; v.e_dm_rdata = edd;
        vecs.push_back(v);
    endtask

    // Inputs change at the falling edge; outputs are sampled 2 time units later, before the rising edge.
    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk_i);
            if_req_i = vecs[i].if_req; if_addr_i = vecs[i].if_addr;
            dm_rd_i = vecs[i].dm_rd; dm_wr_i = vecs[i].dm_wr;
            dm_addr_i = vecs[i].dm_addr; dm_wdata_i = vecs[i].dm_wdata;
            mem_ack_i = vecs[i].mem_ack; mem_rdata_i = vecs[i].mem_rdata;
            #2;
            check($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
            check($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(vecs[i].e_we));
            check($sformatf("v%0d mem_addr", i), mem_addr_o, vecs[i].e_addr);
            check($sformatf("v%0d mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
            check($sformatf("v%0d if_ack", i), 32'(if_ack_o), 32'(vecs[i].e_if_ack));
            check($sformatf("v%0d dm_ack", i), 32'(dm_ack_o), 32'(vecs[i].e_dm_ack));
            check($sformatf("v%0d stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            check($sformatf("v%0d if_data", i), if_data_o, vecs[i].e_if_data);
            check($sformatf("v%0d dm_rdata", i), dm_rdata_o, vecs[i].e_dm_rdata);
            check($sformatf("v%0d err", i), 32'(err_o), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, " mem_we"}, 32'(mem_we_o), 32'd0);
        check({tag, " mem_addr"}, mem_addr_o, 32'd0);
        check({tag, " mem_wdata"}, mem_wdata_o, 32'd0);
        check({tag, " if_ack"}, 32'(if_ack_o), 32'd0);
        check({tag, " dm_ack"}, 32'(dm_ack_o), 32'd0);
        check({tag, " stall"}, 32'(stall_o), 32'd0);
        check({tag, " if_data"}, if_data_o, 32'd0);
        check({tag, " dm_rdata"}, dm_rdata_o, 32'd0);
        check({tag, " err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        // Single fetch (rows 0-5), memory acks in the third request cycle.
        add(1, 32'h10, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h0,  0, 0, 0, 1, 0, 0);
        add(1, 32'h10, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h10, 0, 0, 0, 1, 0, 0);
        add(1, 32'h10, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h10, 0, 0, 0, 1, 0, 0);
        add(1, 32'h10, 0, 0, 0, 0, 1, 32'h8C220004,          1, 0, 32'h10, 0, 0, 0, 1, 0, 0);
        add(1, 32'h10, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h10, 0, 1, 0, 0, 32'h8C220004, 0);
        add(0, 0,      0, 0, 0, 0, 0, 0,                     0, 0, 32'h10, 0, 0, 0, 0, 32'h8C220004, 0);
        // Simultaneous fetch and data write (rows 6-13): data first, fetch after.
        add(1, 32'h14, 0, 1, 32'h20, 32'hDEADBEEF, 0, 0,     0, 0, 32'h10, 0, 0, 0, 1, 32'h8C220004, 0);
        add(1, 32'h14, 0, 1, 32'h20, 32'hDEADBEEF, 0, 0,     1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 1, 32'h8C220004, 0);
        add(1, 32'h14, 0, 1, 32'h20, 32'hDEADBEEF, 1, 32'h12345678, 1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 1, 32'h8C220004, 0);
        add(1, 32'h14, 0, 1, 32'h20, 32'hDEADBEEF, 0, 0,     0, 1, 32'h20, 32'hDEADBEEF, 0, 1, 1, 32'h8C220004, 0);
        add(1, 32'h14, 0, 0, 32'h20, 32'hDEADBEEF, 0, 0,     0, 1, 32'h20, 32'hDEADBEEF, 0, 0, 1, 32'h8C220004, 0);
        add(1, 32'h14, 0, 0, 0, 0, 1, 32'h00000013,          1, 0, 32'h14, 0, 0, 0, 1, 32'h8C220004, 0);
        add(1, 32'h14, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h14, 0, 1, 0, 0, 32'h00000013, 0);
        add(0, 0,      0, 0, 0, 0, 0, 0,                     0, 0, 32'h14, 0, 0, 0, 0, 32'h00000013, 0);
        // Read+write conflict and stray ack in IDLE (rows 14-18), after the starvation run.
        add(0, 0, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0,          0, 0, 32'h100, 0, 0, 0, 1, 32'hF0000100, 32'hD000020C);
        add(0, 0, 1, 1, 32'h40, 32'hA5A5A5A5, 1, 32'h11111111, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 1, 32'hF0000100, 32'hD000020C);
        add(0, 0, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0,          0, 1, 32'h40, 32'hA5A5A5A5, 0, 1, 0, 32'hF0000100, 32'hD000020C);
        add(0, 0, 0, 0, 0, 0, 1, 32'h22222222,               0, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 0, 32'hF0000100, 32'hD000020C);
        add(0, 0, 0, 0, 0, 0, 0, 0,                          0, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 0, 32'hF0000100, 32'hD000020C);
        exp_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state.
        #2;
        check_all_zero("reset");
        #20;
        @(negedge clk_i);
        rst_i = 1'b0;

        run_vecs(0, 13);

        // Starvation guard: data read and fetch both held; memory acks in the first request cycle.
        begin
            int  grants = 0;
            bit  done = 0;
            bit  prev_req = 0;
            @(negedge clk_i);
            if_req_i = 1'b1; if_addr_i = 32'h100;
            dm_rd_i = 1'b1; dm_wr_i = 1'b0; dm_addr_i = 32'h200; dm_wdata_i = '0;
            for (int cyc = 0; cyc < 80 && !done; cyc++) begin
                @(negedge clk_i);
                #1;
                mem_ack_i = 1'b0;
                if (mem_req_o && !prev_req) begin
                    if (exp_q.size() == 0) check("grant_extra", 32'(grants), 32'd6);
                    else check($sformatf("grant_order[%0d]", grants), 32'(mem_addr_o != 32'h100), 32'(exp_q.pop_front()));
                    grants++;
                end
                if (mem_req_o) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = (mem_addr_o == 32'h100) ? 32'hF0000100 : (32'hD0000000 | mem_addr_o);
                end
                if (dm_ack_o) begin
                    check("starve dm_rdata", dm_rdata_o, 32'hD0000000 | dm_addr_i);
                    dm_addr_i = dm_addr_i + 32'd4;
                end
                if (if_ack_o) begin
                    check("starve if_data", if_data_o, 32'hF0000100);
                    if (grants >= 6) begin
                        if_req_i = 1'b0; dm_rd_i = 1'b0; dm_addr_i = '0;
                        done = 1;
                    end
                end
                prev_req = mem_req_o;
            end
            if (!done) check("starve budget", 32'(grants), 32'd6);
            mem_ack_i = 1'b0; mem_rdata_i = '0;
        end

        run_vecs(14, 18);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        // Memory never acks a fetch: expect 8 busy cycles, then an ack with zero data and a sticky error.
        begin
            int busy_cyc = 0;
            bit seen = 0;
            @(negedge clk_i);
            if_req_i = 1'b1; if_addr_i = 32'h300;
            for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
                @(negedge clk_i);
                #1;
                if (mem_req_o) busy_cyc++;
                if (if_ack_o) begin
                    seen = 1;
                    check("timeout busy cycles", 32'(busy_cyc), 32'd8);
                    check("timeout if_data", if_data_o, 32'd0);
                    check("timeout err", 32'(err_o), 32'd1);
                end
            end
            if (!seen) check("timeout ack seen", 32'(seen), 32'd1);
            if_req_i = 1'b0;
            repeat (3) @(negedge clk_i);
            #1;
            check("timeout err sticky", 32'(err_o), 32'd1);
            check("timeout mem_req idle", 32'(mem_req_o), 32'd0);
        end
`endif

        // Asynchronous reset during DM_BUSY, then the held read is granted again.
        begin
            bit got = 0;
            @(negedge clk_i);
            dm_rd_i = 1'b1; dm_addr_i = 32'h80;
            for (int cyc = 0; cyc < 10 && !got; cyc++) begin
                @(negedge clk_i);
                #1;
                if (mem_req_o) got = 1;
            end
            check("pre-reset busy", 32'(got), 32'd1);
            rst_i = 1'b1;
            #1;
            check_all_zero("async reset");
            @(negedge clk_i);
            #1;
            check_all_zero("held reset");
            rst_i = 1'b0;
            @(negedge clk_i);
            #1;
            check("regrant mem_req", 32'(mem_req_o), 32'd1);
            check("regrant mem_addr", mem_addr_o, 32'h80);
            check("regrant mem_we", 32'(mem_we_o), 32'd0);
            mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
            @(negedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            check("regrant dm_ack", 32'(dm_ack_o), 32'd1);
            check("regrant dm_rdata", dm_rdata_o, 32'h0BADF00D);
            check("regrant err", 32'(err_o), 32'd0);
            dm_rd_i = 1'b0;
            @(negedge clk_i);
            #1;
            check("final stall", 32'(stall_o), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
